// File: rtl/muldiv_sequencer_if.sv
// Issue/result bundle between the execute stage (master) and the RV32M
// multiply/divide sequencer (slave).
interface muldiv_sequencer_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  modport master (output start, op, a, b, flush, input busy, stall, done, result);
  modport slave  (input start, op, a, b, flush, output busy, stall, done, result);
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M unit: 32-step shift-add multiplier and restoring divider,
// holding the pipeline from issue until the one-cycle done pulse.
module muldiv_sequencer (
  input  logic              clk_i,
  input  logic              rst_i,
  muldiv_sequencer_if.slave mdu
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_PREP = 3'd1, S_CALC = 3'd2, S_FIX = 3'd3, S_DONE = 3'd4
  } state_e;

  localparam logic [3:0] OP_MUL    = 4'b1000;
  localparam logic [3:0] OP_DIV    = 4'b1001;
  localparam logic [3:0] OP_DIVU   = 4'b1010;
  localparam logic [3:0] OP_REM    = 4'b1011;
  localparam logic [3:0] OP_REMU   = 4'b1100;
  localparam logic [3:0] OP_MULH   = 4'b1101;
  localparam logic [3:0] OP_MULHSU = 4'b1110;
  localparam logic [3:0] OP_MULHU  = 4'b1111;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, div_q, div_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;

  logic        busy_s;
  logic        is_mul_s, a_signed_s, b_signed_s, is_rem_s;
  logic        sign_a_s, sign_b_s, div_zero_s, div_ovf_s;
  logic [31:0] mag_a_s, mag_b_s, quo_s, rem_s, fix_val_s;
  logic [32:0] mul_sum_s, div_shift_s;
  logic [63:0] prod_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mdu.start && mdu.op[3]) state_d = S_PREP;
        else                        state_d = S_IDLE;
      end
      S_PREP: state_d = mdu.flush ? S_IDLE : S_CALC;
      S_CALC: begin
        if (mdu.flush)             state_d = S_IDLE;
        else if (cnt_q == 5'd31)   state_d = S_FIX;
        else                       state_d = S_CALC;
      end
      S_FIX:   state_d = mdu.flush ? S_IDLE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_s     = (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX);
    mdu.busy   = busy_s;
    mdu.done   = (state_q == S_DONE);
    mdu.stall  = busy_s || (mdu.start && (state_q == S_IDLE) && mdu.op[3]);
    mdu.result = result_q;
  end

  // Operand signedness and which signed result (quotient or remainder) is produced.
  always_comb begin
    is_mul_s   = 1'b0;
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    is_rem_s   = 1'b0;
    case (op_q)
      OP_MUL, OP_MULH: begin
        is_mul_s = 1'b1; a_signed_s = 1'b1; b_signed_s = 1'b1;
      end
      OP_MULHSU: begin is_mul_s = 1'b1; a_signed_s = 1'b1; end
      OP_MULHU:  begin is_mul_s = 1'b1; end
      OP_DIV:    begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      OP_REM:    begin a_signed_s = 1'b1; b_signed_s = 1'b1; is_rem_s = 1'b1; end
      OP_REMU:   begin is_rem_s = 1'b1; end
      default:   begin is_mul_s = 1'b0; end
    endcase
  end

  assign sign_a_s    = a_signed_s & a_q[31];
  assign sign_b_s    = b_signed_s & b_q[31];
  assign mag_a_s     = sign_a_s ? (32'd0 - a_q) : a_q;
  assign mag_b_s     = sign_b_s ? (32'd0 - b_q) : b_q;
  assign mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, div_q} : 33'd0);
  assign div_shift_s = {hi_q, lo_q[31]};
  assign prod_s      = neg_q ? (64'd0 - {hi_q, lo_q}) : {hi_q, lo_q};
  assign quo_s       = neg_q ? (32'd0 - lo_q) : lo_q;
  assign rem_s       = neg_q ? (32'd0 - hi_q) : hi_q;
  assign div_zero_s  = (b_q == 32'd0);
  assign div_ovf_s   = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

  // Architectural special cases take precedence over the iterated value.
  always_comb begin
    fix_val_s = 32'd0;
    case (op_q)
      OP_MUL:                       fix_val_s = prod_s[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val_s = prod_s[63:32];
      OP_DIV: begin
        if (div_zero_s)     fix_val_s = 32'hFFFF_FFFF;
        else if (div_ovf_s) fix_val_s = 32'h8000_0000;
        else                fix_val_s = quo_s;
      end
      OP_DIVU: begin
        if (div_zero_s) fix_val_s = 32'hFFFF_FFFF;
        else            fix_val_s = quo_s;
      end
      OP_REM: begin
        if (div_zero_s)     fix_val_s = a_q;
        else if (div_ovf_s) fix_val_s = 32'd0;
        else                fix_val_s = rem_s;
      end
      OP_REMU: begin
        if (div_zero_s) fix_val_s = a_q;
        else            fix_val_s = rem_s;
      end
      default: fix_val_s = 32'd0;
    endcase
  end

  // hi/lo double as product {hi,lo} when multiplying and {rem,quo} when dividing.
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (mdu.start && mdu.op[3]) begin
          op_d = mdu.op;
          a_d  = mdu.a;
          b_d  = mdu.b;
        end else begin
          op_d = op_q;
        end
      end
      S_PREP: begin
        hi_d  = 32'd0;
        lo_d  = mag_a_s;
        div_d = mag_b_s;
        cnt_d = 5'd0;
        neg_d = is_rem_s ? sign_a_s : (sign_a_s ^ sign_b_s);
      end
      S_CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (is_mul_s) begin
          hi_d = mul_sum_s[32:1];
          lo_d = {mul_sum_s[0], lo_q[31:1]};
        end else if (div_shift_s >= {1'b0, div_q}) begin
          hi_d = div_shift_s[31:0] - div_q;
          lo_d = {lo_q[30:0], 1'b1};
        end else begin
          hi_d = div_shift_s[31:0];
          lo_d = {lo_q[30:0], 1'b0};
        end
      end
      S_FIX: begin
        if (!mdu.flush) result_d = fix_val_s;
        else            result_d = result_q;
      end
      default: result_d = result_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q     <= 4'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      div_q    <= 32'd0;
      cnt_q    <= 5'd0;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, abort/reset
// sequences and random operations against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam logic [3:0] OP_MUL    = 4'b1000;
  localparam logic [3:0] OP_DIV    = 4'b1001;
  localparam logic [3:0] OP_DIVU   = 4'b1010;
  localparam logic [3:0] OP_REM    = 4'b1011;
  localparam logic [3:0] OP_REMU   = 4'b1100;
  localparam logic [3:0] OP_MULH   = 4'b1101;
  localparam logic [3:0] OP_MULHSU = 4'b1110;
  localparam logic [3:0] OP_MULHU  = 4'b1111;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t_issue = 0;

  muldiv_sequencer_if mdu();
  muldiv_sequencer dut (.clk_i(clk), .rst_i(rst), .mdu(mdu));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RV32M semantics computed directly with 64-bit and native integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int          ia, ib;
    longint      sa, sb, ua;
    logic [63:0] p;
    logic [31:0] r;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    ua = longint'({32'd0, a});
    ua = longint'({32'd0, b});
    r  = 32'd0;
    case (op)
      OP_MUL:    begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      OP_MULH:   begin p = sa * sb; r = p[63:32]; end
      OP_MULHSU: begin p = sa * ua; r = p[63:32]; end
      OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = ia / ib;
      end
      OP_DIVU: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = ia % ib;
      end
      OP_REMU: r = (b == 32'd0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Waits until the unit is idle, then presents one start for exactly one edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    @(negedge clk);
    while ((mdu.busy || mdu.done) && guard < 80) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 80) chk("idle_wait_timeout", 32'(guard), 32'd0);
    mdu.start = 1'b1;
    mdu.op    = op;
    mdu.a     = a;
    mdu.b     = b;
    #1;
    chk("stall_at_issue", {31'd0, mdu.stall}, 32'd1);
    @(posedge clk);
    #1;
    t_issue   = cyc;
    mdu.start = 1'b0;
  endtask

  task automatic wait_done(output logic [31:0] res, output int lat, output int busy_n,
                           output int stall_n, output logic stall_d);
    res = 32'd0; lat = -1; busy_n = 0; stall_n = 0; stall_d = 1'b1;
    for (int i = 0; i < 60 && lat < 0; i++) begin
      if (mdu.done) begin
        res     = mdu.result;
        lat     = cyc - t_issue + 1;
        stall_d = mdu.stall;
      end else begin
        if (mdu.busy)  busy_n++;
        if (mdu.stall) stall_n++;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic full);
    logic [31:0] res;
    int          lat, bn, sn;
    logic        sd;
    issue(op, a, b);
    wait_done(res, lat, bn, sn, sd);
    chk($sformatf("result op=%b a=%h b=%h", op, a, b), res, exp);
    chk("latency", 32'(lat), 32'd35);
    if (full) begin
      chk("busy_cycles", 32'(bn), 32'd34);
      chk("stall_cycles", 32'(sn), 32'd34);
      chk("stall_at_done", {31'd0, sd}, 32'd0);
    end
  endtask

  initial begin
    vec_t        tbl[16];
    logic [31:0] res, prev;
    int          lat, bn, sn, seen;
    logic        sd;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    mdu.start = 1'b0; mdu.op = 4'd0; mdu.a = 32'd0; mdu.b = 32'd0; mdu.flush = 1'b0;

    tbl[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    tbl[1]  = '{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
    tbl[2]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[3]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[4]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    tbl[5]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    tbl[6]  = '{OP_DIVU,   32'd100,        32'd7,         32'd14};
    tbl[7]  = '{OP_REMU,   32'd100,        32'd7,         32'd2};
    tbl[8]  = '{OP_DIV,    32'h1234_5678,  32'd0,         32'hFFFF_FFFF};
    tbl[9]  = '{OP_DIVU,   32'h1234_5678,  32'd0,         32'hFFFF_FFFF};
    tbl[10] = '{OP_REM,    32'h1234_5678,  32'd0,         32'h1234_5678};
    tbl[11] = '{OP_REMU,   32'h1234_5678,  32'd0,         32'h1234_5678};
    tbl[12] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    tbl[13] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000};
    tbl[14] = '{OP_MULH,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000};
    tbl[15] = '{OP_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};

    // Reset state and combinational stall.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy",   {31'd0, mdu.busy},  32'd0);
    chk("reset_done",   {31'd0, mdu.done},  32'd0);
    chk("reset_stall",  {31'd0, mdu.stall}, 32'd0);
    chk("reset_result", mdu.result,         32'd0);
    mdu.start = 1'b1; mdu.op = OP_MUL;
    #1;
    chk("stall_comb_m", {31'd0, mdu.stall}, 32'd1);
    mdu.op = 4'b0111;
    #1;
    chk("stall_comb_nonm", {31'd0, mdu.stall}, 32'd0);
    @(posedge clk);
    #1;
    mdu.start = 1'b0;
    chk("nonm_start_ignored", {31'd0, mdu.busy}, 32'd0);

    for (int i = 0; i < 16; i++) run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b1);

    // Flush at T+10: idle at T+11, no done, result held.
    prev = tbl[15].exp;
    issue(OP_MUL, 32'd5, 32'd9);
    repeat (9) @(posedge clk);
    #1;
    mdu.flush = 1'b1;
    @(posedge clk);
    #1;
    mdu.flush = 1'b0;
    chk("flush_busy_low", {31'd0, mdu.busy}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (mdu.done || mdu.busy) seen++;
    end
    chk("flush_no_done", 32'(seen), 32'd0);
    chk("flush_result_held", mdu.result, prev);

    // Start at T+5 with other operands is ignored.
    issue(OP_MUL, 32'd3, 32'd4);
    repeat (4) @(posedge clk);
    #1;
    mdu.start = 1'b1; mdu.op = OP_DIV; mdu.a = 32'd100; mdu.b = 32'd7;
    @(posedge clk);
    #1;
    mdu.start = 1'b0;
    wait_done(res, lat, bn, sn, sd);
    chk("ignored_start_result", res, 32'd12);
    chk("ignored_start_latency", 32'(lat), 32'd35);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (mdu.done || mdu.busy) seen++;
    end
    chk("ignored_start_no_second_op", 32'(seen), 32'd0);

    // Reset at T+20 (with flush) aborts; a MUL right after completes.
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1; mdu.flush = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; mdu.flush = 1'b0;
    chk("rst_busy_low", {31'd0, mdu.busy}, 32'd0);
    chk("rst_no_done",  {31'd0, mdu.done}, 32'd0);
    chk("rst_result",   mdu.result,        32'd0);
    run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);

    for (int i = 0; i < 200; i++) begin
      rop = {1'b1, 3'($urandom_range(0, 7))};
      ra  = rnd_opnd();
      rb  = rnd_opnd();
      run_op(rop, ra, rb, ref_model(rop, ra, rb), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
